// File: rtl/enemy_attack_array.sv
// Multi-channel enemy strike overlay: NUM_CH independent strike FSMs sharing one sprite-ROM address path.
// Optional saturating hit counter (Hit_Count / Hit_Count_Clr) is built when ENEMY_ATTACK_HIT_COUNT_EN is defined.
module enemy_attack_array #(
   parameter int NUM_CH         = 4,
   parameter int COORD_W        = 9,
   parameter int WIDTH          = 18,
   parameter int HEIGHT         = 20,
   parameter int ANIM_FRAMES    = 2,
   parameter int FRAME_DIV      = 4,
   parameter int ACTIVE_TICKS   = 2,
   parameter int COOLDOWN_TICKS = 4,
   parameter int ADDR_W         = 10
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       frame_clk,
   input  logic [NUM_CH*COORD_W-1:0]  Target_X,
   input  logic [NUM_CH*COORD_W-1:0]  Target_Y,
   input  logic [COORD_W-1:0]         PixelX,
   input  logic [COORD_W-1:0]         PixelY,
   input  logic [NUM_CH-1:0]          Attack_Ready,
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
   input  logic                       Hit_Count_Clr,
   output logic [7:0]                 Hit_Count,
`endif
   output logic                       is_obj,
   output logic [ADDR_W-1:0]          Obj_address,
   output logic [NUM_CH-1:0]          Obj_On,
   output logic [NUM_CH-1:0]          Hit_Pulse
);

   localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int CNT_MAX = (ACTIVE_TICKS > COOLDOWN_TICKS) ? ACTIVE_TICKS : COOLDOWN_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int ANIM_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

   logic [2:0]       fc_sync_reg;
   logic             edge_reg;
   logic             tick_reg;
   logic [DIV_W-1:0] div_reg;

   // fc_sync_reg[1:0] is the two-flop synchroniser; [2] only serves edge detection
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fc_sync_reg <= '0;
         edge_reg    <= 1'b0;
         tick_reg    <= 1'b0;
         div_reg     <= '0;
      end else begin
         fc_sync_reg <= {fc_sync_reg[1:0], frame_clk};
         edge_reg    <= fc_sync_reg[1] & ~fc_sync_reg[2];
         tick_reg    <= 1'b0;
         if (edge_reg) begin
            if (div_reg == DIV_W'(FRAME_DIV - 1)) begin
               div_reg  <= '0;
               tick_reg <= 1'b1;
            end else begin
               div_reg <= div_reg + 1'b1;
            end
         end
      end
   end

   logic [NUM_CH-1:0] hit_vec;
   logic [ADDR_W-1:0] addr_arr [NUM_CH];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t            state_reg;
         logic [CNT_W-1:0]  cnt_reg;
         logic [ANIM_W-1:0] anim_reg;
         logic              on_reg;
         logic              pulse_reg;
         logic [COORD_W:0]  dx;
         logic [COORD_W:0]  dy;

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               anim_reg  <= '0;
               on_reg    <= 1'b0;
               pulse_reg <= 1'b0;
            end else begin
               pulse_reg <= 1'b0;
               if (!Attack_Ready[gi]) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  anim_reg  <= '0;
                  on_reg    <= 1'b0;
               end else begin
                  case (state_reg)
                     IDLE: begin
                        state_reg <= ACTIVE;
                        cnt_reg   <= '0;
                        anim_reg  <= '0;
                        on_reg    <= 1'b1;
                        pulse_reg <= 1'b1;
                     end
                     ACTIVE: if (tick_reg) begin
                        if (cnt_reg == CNT_W'(ACTIVE_TICKS - 1)) begin
                           state_reg <= COOLDOWN;
                           cnt_reg   <= '0;
                           on_reg    <= 1'b0;
                        end else begin
                           cnt_reg  <= cnt_reg + 1'b1;
                           anim_reg <= (anim_reg == ANIM_W'(ANIM_FRAMES - 1)) ? '0 : anim_reg + 1'b1;
                        end
                     end
                     COOLDOWN: if (tick_reg) begin
                        if (cnt_reg == CNT_W'(COOLDOWN_TICKS - 1)) begin
                           state_reg <= ACTIVE;
                           cnt_reg   <= '0;
                           anim_reg  <= '0;
                           on_reg    <= 1'b1;
                           pulse_reg <= 1'b1;
                        end else begin
                           cnt_reg <= cnt_reg + 1'b1;
                        end
                     end
                     default: begin
                        state_reg <= IDLE;
                        on_reg    <= 1'b0;
                     end
                  endcase
               end
            end
         end

         // One extra bit: a pixel left of/above the origin wraps to a huge offset and fails the bound
         assign dx = {1'b0, PixelX} - {1'b0, Target_X[gi*COORD_W +: COORD_W]};
         assign dy = {1'b0, PixelY} - {1'b0, Target_Y[gi*COORD_W +: COORD_W]};

         assign hit_vec[gi]  = on_reg && (dx < (COORD_W+1)'(WIDTH)) && (dy < (COORD_W+1)'(HEIGHT));
         assign addr_arr[gi] = ADDR_W'(anim_reg) * ADDR_W'(WIDTH * HEIGHT)
                             + ADDR_W'(dy) * ADDR_W'(WIDTH) + ADDR_W'(dx);
         assign Obj_On[gi]    = on_reg;
         assign Hit_Pulse[gi] = pulse_reg;
      end
   endgenerate

   // Scan from the top so the lowest-index hitting channel is written last and wins
   always_comb begin
      is_obj      = 1'b0;
      Obj_address = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            is_obj      = 1'b1;
            Obj_address = addr_arr[i];
         end
      end
   end

`ifdef ENEMY_ATTACK_HIT_COUNT_EN
   logic [8:0] hc_sum;
   assign hc_sum = {1'b0, Hit_Count} + 9'($countones(Hit_Pulse));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         Hit_Count <= '0;
      else if (Hit_Count_Clr)
         Hit_Count <= '0;
      else
         Hit_Count <= (hc_sum > 9'd255) ? 8'hFF : hc_sum[7:0];
   end
`endif

endmodule

// File: tb/tb_enemy_attack_array.sv
// Randomised bench for enemy_attack_array against a tick-phase model of each channel,
// plus directed scenarios with hand-computed expectations.
module tb_enemy_attack_array;
   localparam int NUM_CH = 4, CW = 9, W = 18, H = 20, AF = 2, FD = 4, AT = 2, CT = 4, AW = 10;

   logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
   logic [NUM_CH*CW-1:0] Target_X = '0, Target_Y = '0;
   logic [CW-1:0]        PixelX = '0, PixelY = '0;
   logic [NUM_CH-1:0]    Attack_Ready = '0;
   logic                 is_obj;
   logic [AW-1:0]        Obj_address;
   logic [NUM_CH-1:0]    Obj_On, Hit_Pulse;
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
   logic                 Hit_Count_Clr = 1'b0;
   logic [7:0]           Hit_Count;
`endif

   int n_cmp = 0, n_fail = 0;
   // Model: each engaged channel keeps the number of ticks since its strike began
   int eng [NUM_CH];
   int ph  [NUM_CH];
   bit mhit [NUM_CH];
   bit fc_prev;
   int rises, cyc, n_ticks, fc_cnt, hc;
   int tick_due [$];

   enemy_attack_array dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
      .Target_X(Target_X), .Target_Y(Target_Y), .PixelX(PixelX), .PixelY(PixelY),
      .Attack_Ready(Attack_Ready),
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
      .Hit_Count_Clr(Hit_Count_Clr), .Hit_Count(Hit_Count),
`endif
      .is_obj(is_obj), .Obj_address(Obj_address), .Obj_On(Obj_On), .Hit_Pulse(Hit_Pulse)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         eng[i] = 0; ph[i] = 0; mhit[i] = 0;
      end
      fc_prev = 0; rises = 0; hc = 0;
      tick_due.delete();
   endtask

   // Applied at every rising Clk edge with the inputs that were stable before it
   task automatic model_edge();
      bit tick, rise;
      cyc++;
      if (!Reset_n) begin
         model_reset();
         return;
      end
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
      begin
         int pc = 0;
         for (int i = 0; i < NUM_CH; i++) pc += int'(mhit[i]);
         if (Hit_Count_Clr) hc = 0;
         else hc = (hc + pc > 255) ? 255 : hc + pc;
      end
`endif
      tick = (tick_due.size() > 0) && (tick_due[0] == cyc);
      if (tick) begin
         void'(tick_due.pop_front());
         n_ticks++;
      end
      // Every FD-th rise of frame_clk yields a tick used 4 Clk edges after the rise is first sampled
      rise = frame_clk && !fc_prev;
      fc_prev = frame_clk;
      if (rise) begin
         rises++;
         if (rises == FD) begin
            rises = 0;
            tick_due.push_back(cyc + 4);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         mhit[i] = 0;
         if (!Attack_Ready[i]) begin
            eng[i] = 0; ph[i] = 0;
         end else if (eng[i] == 0) begin
            eng[i] = 1; ph[i] = 0; mhit[i] = 1;
         end else if (tick) begin
            ph[i]++;
            if (ph[i] == AT + CT) begin
               ph[i] = 0; mhit[i] = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [NUM_CH-1:0] e_on, e_hit;
      int e_obj, e_addr, dx, dy;
      e_obj = 0; e_addr = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         e_on[i]  = (eng[i] != 0) && (ph[i] < AT);
         e_hit[i] = mhit[i];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         dx = int'(PixelX) - int'(Target_X[i*CW +: CW]);
         dy = int'(PixelY) - int'(Target_Y[i*CW +: CW]);
         if (e_obj == 0 && e_on[i] && dx >= 0 && dx < W && dy >= 0 && dy < H) begin
            e_obj  = 1;
            e_addr = ((ph[i] % AF) * W * H + dy * W + dx) % (1 << AW);
         end
      end
      chk("obj_on", int'(Obj_On), int'(e_on));
      chk("hit_pulse", int'(Hit_Pulse), int'(e_hit));
      chk("is_obj", int'(is_obj), e_obj);
      chk("obj_address", int'(Obj_address), e_addr);
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
      chk("hit_count", int'(Hit_Count), hc);
`endif
   endtask

   task automatic step();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      compare_all();
   endtask

   // Steps with a regular frame_clk: 4 Clk high, 4 Clk low
   task automatic cycles(input int n);
      repeat (n) begin
         step();
         fc_cnt++;
         frame_clk = ((fc_cnt % 8) < 4);
      end
   endtask

   task automatic set_tgt(input int c, input int x, input int y);
      Target_X[c*CW +: CW] = CW'(x);
      Target_Y[c*CW +: CW] = CW'(y);
   endtask

   task automatic pulse_reset();
      #2 Reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_obj_on", int'(Obj_On), 0);
      chk("async_rst_hit", int'(Hit_Pulse), 0);
      chk("async_rst_is_obj", int'(is_obj), 0);
      chk("async_rst_addr", int'(Obj_address), 0);
      step();
      Reset_n = 1'b1;
   endtask

   initial begin
      int guard, t0, c, v;
      model_reset();
      cyc = 0; n_ticks = 0; fc_cnt = 0;
      repeat (3) step();
      Reset_n = 1'b1;
      step();
      chk("reset_obj_on", int'(Obj_On), 0);
      chk("reset_hit", int'(Hit_Pulse), 0);
      chk("reset_is_obj", int'(is_obj), 0);
      chk("reset_addr", int'(Obj_address), 0);

      // First strike, pixel bounds and the 6-tick strike period
      set_tgt(0, 100, 50);
      Attack_Ready = 4'b0001;
      step();
      chk("start_hit", int'(Hit_Pulse), 1);
      chk("start_on", int'(Obj_On), 1);
      t0 = n_ticks;
      cycles(1);
      chk("pulse_one_cycle", int'(Hit_Pulse), 0);
      guard = 0;
      while (ph[0] != 1 && guard < 400) begin cycles(1); guard++; end
      chk("wait_anim1", int'(guard < 400), 1);
      PixelX = 117; PixelY = 69; #1;
      chk("px_in_obj", int'(is_obj), 1);
      chk("px_in_addr", int'(Obj_address), 719);
      PixelX = 118; #1;
      chk("px_right_edge", int'(is_obj), 0);
      PixelX = 117; PixelY = 70; #1;
      chk("px_bottom_edge", int'(is_obj), 0);
      guard = 0;
      while (ph[0] != 2 && guard < 400) begin cycles(1); guard++; end
      chk("cool_off", int'(Obj_On[0]), 0);
      guard = 0;
      while (Hit_Pulse[0] !== 1'b1 && guard < 600) begin cycles(1); guard++; end
      chk("period_ticks", n_ticks - t0, 6);

      // Abort on the same cycle as a tick, then re-arm
      set_tgt(1, 0, 0);
      Attack_Ready[1] = 1'b1;
      cycles(1);
      chk("ch1_hit", int'(Hit_Pulse[1]), 1);
      guard = 0;
      while (!(tick_due.size() > 0 && tick_due[0] == cyc + 1) && guard < 400) begin cycles(1); guard++; end
      chk("wait_tick", int'(guard < 400), 1);
      Attack_Ready[1] = 1'b0;
      cycles(1);
      chk("abort_off", int'(Obj_On[1]), 0);
      Attack_Ready[1] = 1'b1;
      cycles(1);
      chk("rearm_hit", int'(Hit_Pulse[1]), 1);
      PixelX = 0; PixelY = 0; #1;
      chk("rearm_obj", int'(is_obj), 1);
      chk("rearm_addr", int'(Obj_address), 0);

      // Origin near the right edge of the coordinate range must not wrap
      Attack_Ready[1] = 1'b0;
      set_tgt(3, 500, 0);
      Attack_Ready[3] = 1'b1;
      cycles(1);
      PixelX = 5; PixelY = 0; #1;
      chk("no_wrap", int'(is_obj), 0);
      PixelX = 500; #1;
      chk("x500_obj", int'(is_obj), 1);

      // Overlap: channel 0 (anim 0) beats channel 2 (anim 1)
      Attack_Ready = 4'b0000;
      cycles(1);
      set_tgt(0, 10, 10); set_tgt(2, 10, 10);
      Attack_Ready = 4'b0100;
      guard = 0;
      while (ph[2] != 1 && guard < 400) begin cycles(1); guard++; end
      Attack_Ready[0] = 1'b1;
      cycles(1);
      PixelX = 10; PixelY = 10; #1;
      chk("overlap_obj", int'(is_obj), 1);
      chk("overlap_ch0", int'(Obj_address), 0);
      Attack_Ready[0] = 1'b0;
      cycles(1);
      chk("overlap_ch2", int'(Obj_address), 360);

      // Async reset while channel 0 cools down and channel 1 is striking
      Attack_Ready = 4'b0001;
      set_tgt(1, 0, 0);
      guard = 0;
      while (ph[0] != 2 && guard < 400) begin cycles(1); guard++; end
      chk("cool_state_off", int'(Obj_On[0]), 0);
      Attack_Ready[1] = 1'b1;
      PixelX = 3; PixelY = 3;
      cycles(1);
      pulse_reset();
      cycles(2);

`ifdef ENEMY_ATTACK_HIT_COUNT_EN
      Attack_Ready = 4'b0000;
      Hit_Count_Clr = 1'b1;
      cycles(1);
      Hit_Count_Clr = 1'b0;
      cycles(1);
      guard = 0;
      while (hc < 254 && guard < 500) begin
         v = (254 - hc > 4) ? 4 : 254 - hc;
         Attack_Ready = NUM_CH'((1 << v) - 1);
         cycles(1);
         Attack_Ready = 4'b0000;
         cycles(1);
         guard++;
      end
      chk("hc_at_254", int'(Hit_Count), 254);
      Attack_Ready = 4'b0111;
      cycles(1);
      Attack_Ready = 4'b0000;
      cycles(1);
      chk("hc_saturate", int'(Hit_Count), 255);
      Attack_Ready = 4'b0011;
      cycles(1);
      Hit_Count_Clr = 1'b1;
      Attack_Ready = 4'b0000;
      cycles(1);
      chk("hc_clear_priority", int'(Hit_Count), 0);
      Hit_Count_Clr = 1'b0;
`endif

      // Randomised phase
      Attack_Ready = 4'b1111;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 29) == 0) begin
            c = int'($urandom_range(0, NUM_CH - 1));
            Attack_Ready[c] = ~Attack_Ready[c];
         end
         if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
         if ($urandom_range(0, 99) == 0) begin
            c = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 2) == 0) begin
               v = int'($urandom_range(0, NUM_CH - 1));
               set_tgt(c, int'(Target_X[v*CW +: CW]), int'(Target_Y[v*CW +: CW]));
            end else begin
               set_tgt(c, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
            end
         end
         c = int'($urandom_range(0, NUM_CH - 1));
         if ($urandom_range(0, 7) == 0) begin
            PixelX = CW'($urandom_range(0, 511));
            PixelY = CW'($urandom_range(0, 511));
         end else begin
            PixelX = CW'(int'(Target_X[c*CW +: CW]) + int'($urandom_range(0, W + 3)) - 2);
            PixelY = CW'(int'(Target_Y[c*CW +: CW]) + int'($urandom_range(0, H + 3)) - 2);
         end
`ifdef ENEMY_ATTACK_HIT_COUNT_EN
         Hit_Count_Clr = ($urandom_range(0, 63) == 0);
`endif
         if (n == 2000) pulse_reset();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
